// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the accumulator calculator.
//   op_t    - 3-bit opcode as presented on OpIn
//   state_t - control state (IDLE accepts requests, MUL runs the multiply)
//   OP_W    - opcode width
package calc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_OR   = 3'd2,
    OP_EQ   = 3'd3,
    OP_AND  = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_UNDO = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/calc_history.sv
// calc_history: LIFO undo stack built on a ring buffer.
//   clock, Reset - clock and asynchronous active-high reset
//   push, din    - store din as the newest entry; when full the oldest
//                  entry is overwritten and count stays at DEPTH
//   pop          - drop the newest entry; no effect when empty
//   dout         - newest entry (meaningless while count==0)
//   count        - number of valid entries, 0..DEPTH
// push has priority if both are raised in the same cycle.
module calc_history #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;      // next slot to write (oldest slot when full)
  logic [PTR_W-1:0] wp_nxt;
  logic [PTR_W-1:0] top_idx; // slot holding the newest entry

  assign wp_nxt  = (wp == LAST) ? '0 : wp + PTR_W'(1);
  assign top_idx = (wp == '0) ? LAST : wp - PTR_W'(1);
  assign dout    = mem[top_idx];

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp_nxt;
      if (count != FULL) count <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      wp    <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/param_calculator.sv
// param_calculator: WIDTH-bit accumulator calculator with an iterative
// multiplier and a DEPTH-deep undo history.
//   clock     - system clock, rising edge
//   Reset     - asynchronous, active-high reset
//   Enter     - request level; only a rising edge while idle is accepted
//   NumIn     - operand
//   OpIn      - opcode (ADD SUB OR EQ AND XOR MUL UNDO)
//   NumOut    - accumulator
//   Busy      - multiply in progress
//   Overflow  - carry/borrow/high-half status of the last completed op
//   HistCount - number of valid undo entries
// Build option: define CALC_SATURATE_EN to clamp ADD/MUL overflow to all
// ones and SUB borrow to zero instead of wrapping.
module param_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic                       Enter,
  input  logic [WIDTH-1:0]           NumIn,
  input  logic [OP_W-1:0]            OpIn,
  output logic [WIDTH-1:0]           NumOut,
  output logic                       Busy,
  output logic                       Overflow,
  output logic [$clog2(DEPTH+1)-1:0] HistCount
);

  localparam int CW = $clog2(WIDTH+1);

  state_t             state, state_d;
  logic               enter_q;
  logic [WIDTH-1:0]   acc, acc_d;
  logic               ovf, ovf_d;
  logic [WIDTH-1:0]   mplier, mplier_d;
  logic [2*WIDTH-1:0] prod, prod_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               push, pop;
  logic [WIDTH-1:0]   hist_top;
  logic               accept;
  op_t                op;

  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   sub_res;
  logic               borrow;
  logic [WIDTH:0]     hsum;
  logic [2*WIDTH-1:0] prod_step;

  assign op       = op_t'(OpIn);
  assign accept   = Enter & ~enter_q & (state == IDLE);
  assign add_full = {1'b0, acc} + {1'b0, NumIn};
  assign sub_res  = acc - NumIn;
  assign borrow   = NumIn > acc;

  // Right-shifting shift-add: add the multiplicand into the high half when
  // the current multiplier LSB is set, then shift the whole product right.
  // After WIDTH steps the product is fully aligned.
  assign hsum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? acc : '0)};
  assign prod_step = {hsum, prod[WIDTH-1:1]};

  calc_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_hist (
    .clock (clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (acc),
    .dout  (hist_top),
    .count (HistCount)
  );

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      enter_q <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
      mplier  <= '0;
      prod    <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      enter_q <= Enter;
      acc     <= acc_d;
      ovf     <= ovf_d;
      mplier  <= mplier_d;
      prod    <= prod_d;
      cnt     <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    ovf_d    = ovf;
    mplier_d = mplier;
    prod_d   = prod;
    cnt_d    = cnt;
    push     = 1'b0;
    pop      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          // Everything except UNDO records the pre-op accumulator.
          push = (op != OP_UNDO);
          unique case (op)
            OP_ADD: begin
              acc_d = add_full[WIDTH-1:0];
              ovf_d = add_full[WIDTH];
`ifdef CALC_SATURATE_EN
              if (add_full[WIDTH]) acc_d = '1;
`endif
            end
            OP_SUB: begin
              acc_d = sub_res;
              ovf_d = borrow;
`ifdef CALC_SATURATE_EN
              if (borrow) acc_d = '0;
`endif
            end
            OP_OR: begin
              acc_d = acc | NumIn;
              ovf_d = 1'b0;
            end
            OP_EQ: begin
              acc_d = (acc == NumIn) ? WIDTH'(1) : '0;
              ovf_d = 1'b0;
            end
            OP_AND: begin
              acc_d = acc & NumIn;
              ovf_d = 1'b0;
            end
            OP_XOR: begin
              acc_d = acc ^ NumIn;
              ovf_d = 1'b0;
            end
            OP_MUL: begin
              // Accumulator keeps the multiplicand; Overflow is left alone
              // until the multiply completes.
              state_d  = MUL;
              mplier_d = NumIn;
              prod_d   = '0;
              cnt_d    = CW'(WIDTH);
            end
            OP_UNDO: begin
              pop   = 1'b1;
              ovf_d = 1'b0;
              if (HistCount != '0) acc_d = hist_top;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        prod_d   = prod_step;
        mplier_d = mplier >> 1;
        cnt_d    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          acc_d   = prod_step[WIDTH-1:0];
          ovf_d   = |prod_step[2*WIDTH-1:WIDTH];
`ifdef CALC_SATURATE_EN
          if (|prod_step[2*WIDTH-1:WIDTH]) acc_d = '1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign NumOut   = acc;
  assign Busy     = (state == MUL);
  assign Overflow = ovf;

endmodule
